ps2_keyboard: RTL and testbench

PS/2 keyboard receiver and bus slave; sits directly downstream of the system bus decoder on its PS/2 port (slave strobed for word address 0xFFFF_FC00). Deserialises device-to-host PS/2 frames, checks parity, queues scancodes in a FIFO, and returns them to the CPU through a single read/pop register with a registered acknowledge.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_fifo.sv | 52 +++++
 rtl/ps2_keyboard.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 keyboard receiver: frame FSM states,
// read-word field positions and write command bits.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam int VALID_BIT = 8;
    localparam int PERR_BIT  = 9;
    localparam int OVF_BIT   = 10;
    localparam int COUNT_LSB = 16;

    localparam int FLUSH_BIT = 0;
    localparam int CLR_BIT   = 1;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] byte_v, input logic par_v);
        return ^{byte_v, par_v};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous scancode FIFO with push, pop, flush and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with a single read/pop bus register.
// Build option PS2_KEYBOARD_IRQ_EN enables the registered interrupt output.
//
// state  | meaning
// IDLE   | waiting for a start bit (0) on a ps2_clk falling edge
// DATA   | shifting in eight data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then pushing or flagging
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic [1:0]  sel_i,
    input  logic        rd_i,
    input  logic        we_i,
    output logic        ack_o,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic        irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [1:0]    raw;
    logic [1:0]    filt;
    logic [FW-1:0] flt_cnt [2];
    logic          filt_clk_q;
    logic          fall;
    logic          sd;

    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo;
    logic          fr_push;
    logic          fr_perr;
    logic [7:0]    fr_byte;

    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          strobe;
    logic          start;
    logic          pop;
    logic          flush;
    logic          clr;
    logic          perr;
    logic          ovf;
    logic [31:0]   rd_word;
    logic          unused_bus;

    assign unused_bus = ^{addr_i, sel_i, data_i[31:2]};

    // Index 0 carries ps2_clk, index 1 carries ps2_data.
    assign raw = {data_sync[1], clk_sync[1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            filt       <= 2'b11;
            filt_clk_q <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= FW'(FILTER_LEN - 1);
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_i};
            data_sync  <= {data_sync[0], ps2_data_i};
            filt_clk_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    flt_cnt[i] <= FW'(FILTER_LEN - 1);
                end else if (flt_cnt[i] == '0) begin
                    filt[i]    <= raw[i];
                    flt_cnt[i] <= FW'(FILTER_LEN - 1);
                end else begin
                    flt_cnt[i] <= flt_cnt[i] - FW'(1);
                end
            end
        end
    end

    assign fall = filt_clk_q & ~filt[0];
    assign sd   = filt[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tmo     <= TW'(TIMEOUT - 1);
            fr_push <= 1'b0;
            fr_perr <= 1'b0;
            fr_byte <= '0;
        end else begin
            fr_push <= 1'b0;
            fr_perr <= 1'b0;
            if (fall) begin
                tmo <= TW'(TIMEOUT - 1);
                case (state)
                    IDLE: begin
                        if (!sd) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {sd, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= sd;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (sd) begin
                            if (parity_ok(shreg, par_bit)) begin
                                fr_push <= 1'b1;
                                fr_byte <= shreg;
                            end else begin
                                fr_perr <= 1'b1;
                            end
                        end
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                if (tmo == '0) state <= IDLE;
                else           tmo   <= tmo - TW'(1);
            end
        end
    end

    ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fr_push),
        .pop   (pop),
        .flush (flush),
        .din   (fr_byte),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Side effects fire only on the first strobe cycle of a transaction.
    assign strobe = rd_i | we_i;
    assign start  = strobe & ~ack_o;
    assign pop    = start & rd_i;
    assign flush  = start & ~rd_i & we_i & data_i[FLUSH_BIT];
    assign clr    = start & (rd_i | (we_i & data_i[CLR_BIT]));

    always_comb begin
        rd_word                        = '0;
        rd_word[7:0]                   = fifo_empty ? 8'h00 : fifo_dout;
        rd_word[VALID_BIT]             = ~fifo_empty;
        rd_word[PERR_BIT]              = perr;
        rd_word[OVF_BIT]               = ovf;
        rd_word[COUNT_LSB +: CW]       = fifo_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_o  <= 1'b0;
            data_o <= '0;
            perr   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            ack_o <= strobe;
            if (pop) data_o <= rd_word;
            // A new error in the same cycle as a clear is kept, not lost.
            if (fr_perr)  perr <= 1'b1;
            else if (clr) perr <= 1'b0;
            if (fr_push && fifo_full && !pop && !flush) ovf <= 1'b1;
            else if (clr)                               ovf <= 1'b0;
        end
    end

`ifdef PS2_KEYBOARD_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq_o <= 1'b0;
        else      irq_o <= ~fifo_empty | perr | ovf;
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: reads queue expected words, a monitor
// compares them against data_o on every read acknowledge.
module tb_ps2_keyboard;
    localparam int TMO  = 300;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_i = 32'hFFFF_FC00;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [1:0]  sel_i = 2'b11;
    logic        rd_i = 1'b0;
    logic        we_i = 1'b0;
    logic        ack_o;
    logic        ps2_clk_i = 1'b1;
    logic        ps2_data_i = 1'b1;
    logic        irq_o;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_acks  = 0;
    logic ack_q    = 1'b0;
    logic irq_exp;

    ps2_keyboard #(.FIFO_DEPTH(8), .FILTER_LEN(8), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .sel_i      (sel_i),
        .rd_i       (rd_i),
        .we_i       (we_i),
        .ack_o      (ack_o),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && ack_o && !ack_q) begin
            if (rd_i) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read: got 0x%08h with nothing expected", data_o);
                end else begin
                    e = sb.pop_front();
                    if (((data_o ^ e.exp) & e.mask) != 0) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%08h expected 0x%08h mask 0x%08h",
                                 e.name, data_o, e.exp, e.mask);
                    end
                end
            end else begin
                wr_acks++;
            end
        end
        ack_q = ack_o;
    end

    task automatic finish_handshake(input string nm, input int hold);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_o) begin got = 1; break; end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s_ack_timeout: ack 0 expected 1", nm);
        end
        repeat (hold) @(negedge clk);
        #1;
        rd_i = 1'b0;
        we_i = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ack_o) begin got = 1; break; end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s_ack_release: ack 1 expected 0", nm);
        end
    endtask

    task automatic bus_read(input string nm, input logic [31:0] exp,
                            input logic [31:0] mask, input int hold);
        exp_t e;
        e.exp = exp; e.mask = mask; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        #1 rd_i = 1'b1;
        finish_handshake(nm, hold);
    endtask

    task automatic bus_write(input string nm, input logic [31:0] wd);
        @(negedge clk);
        #1;
        data_i = wd;
        we_i   = 1'b1;
        finish_handshake(nm, 2);
        data_i = '0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic stop_v, input int nbits);
        logic [10:0] fr;
        fr = {stop_v, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = fr[i];
            repeat (HALF) @(posedge clk);
            ps2_clk_i = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
        repeat (30) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks_before;
`ifdef PS2_KEYBOARD_IRQ_EN
        irq_exp = 1'b1;
`else
        irq_exp = 1'b0;
`endif
        // Reset held with strobes toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd_i = ~rd_i;
            we_i = i[1];
            @(negedge clk);
            check("reset_ack", {31'd0, ack_o}, 32'd0);
        end
        check("reset_data", data_o, 32'd0);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        rd_i = 1'b0;
        we_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        bus_read("read_after_reset", 32'h0000_0000, 32'hFFFF_FFFF, 0);

        // Good frame 0x1C
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        check("irq_with_data", {31'd0, irq_o}, {31'd0, irq_exp});
        bus_read("read_1c", 32'h0001_011C, 32'hFFFF_FFFF, 3);
        bus_read("read_1c_empty", 32'h0000_0000, 32'hFFFF_FFFF, 0);
        repeat (2) @(negedge clk);
        check("irq_after_drain", {31'd0, irq_o}, 32'd0);

        // Parity error
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        bus_read("read_perr", 32'h0000_0200, 32'hFFFF_FFFF, 0);
        bus_read("read_perr_cleared", 32'h0000_0000, 32'hFFFF_FFFF, 0);

        // Stop bit 0 dropped silently
        send_frame(8'h5A, 1'b0, 1'b0, 11);
        bus_read("read_bad_stop", 32'h0000_0000, 32'hFFFF_FFFF, 0);

        // Overflow: nine frames into an eight-entry FIFO
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b1, 11);
        bus_read("read_ovf_first", 32'h0008_0501, 32'hFFFF_FFFF, 2);
        for (int k = 2; k <= 8; k++)
            bus_read("read_ovf_drain", (32'(9 - k) << 16) | 32'h100 | 32'(k), 32'hFFFF_FFFF, 0);
        bus_read("read_ovf_empty", 32'h0000_0000, 32'hFFFF_FFFF, 0);

        // Partial frame abandoned by timeout
        send_frame(8'hA5, 1'b0, 1'b1, 4);
        repeat (TMO + 10) @(posedge clk);
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        bus_read("read_after_timeout", 32'h0001_01F0, 32'hFFFF_FFFF, 0);

        // Flush racing a new frame's push
        send_frame(8'h11, 1'b0, 1'b1, 11);
        send_frame(8'h22, 1'b0, 1'b1, 11);
        send_frame(8'h33, 1'b0, 1'b1, 11);
        acks_before = wr_acks;
        fork
            send_frame(8'h44, 1'b0, 1'b1, 11);
            begin
                repeat (425) @(posedge clk);
                bus_write("flush_write", 32'h0000_0001);
            end
        join
        check("flush_ack_once", 32'(wr_acks - acks_before), 32'd1);
        bus_read("read_after_flush", 32'h0000_0000, 32'h000E_0600, 0);
        bus_read("read_after_flush_empty", 32'h0000_0000, 32'hFFFF_FFFF, 0);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
